pic_inta_sequencer: RTL and testbench
=====================================

Name: pic_inta_sequencer

Overview:
- Sequences the 8259 interrupt-acknowledge cycle between the CPU INTA pulses, the IRR and the in-service register (ISR).
- Resolves the highest-priority unmasked request and drives INT.
- On the first INTA pulse: sets the winning ISR bit and commands the IRR to clear that request.
- On the second INTA pulse: drives the 8-bit vector onto the data bus.
- Also owns ISR clearing: EOI, AEOI and rotate-on-EOI.

Parameters:
- NUM_IR, 8, number of interrupt request lines (fixed at 8; sizes the IR vectors).
- LVL_W, 3, width of level encodings.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- irr  in  8  request bits from the IRR.
- imr  in  8  mask bits; 1 = masked.
- inta_n  in  1  CPU acknowledge, active low; synchronous to clk, ≥2 cycles low and ≥1 cycle high per pulse.
- vec_base  in  5  ICW2 T7..T3.
- aeoi  in  1  automatic-EOI mode.
- eoi_strobe  in  1  one-cycle EOI command.
- eoi_specific  in  1  qualifies eoi_strobe: 1 = specific, 0 = non-specific.
- eoi_level  in  3  target level for specific EOI.
- eoi_rotate  in  1  qualifies eoi_strobe: rotate priority to cleared level.
- int_out  out  1  interrupt request to CPU.
- isr  out  8  in-service register.
- highest_priority  out  3  level latched at first INTA; feeds IRR.
- current_pulse  out  1  0 during/after pulse 1, 1 during pulse 2.
- irr_clr  out  1  one-cycle strobe: IRR clears bit highest_priority.
- data_out  out  8  vector {vec_base, level}.
- data_oe  out  1  data bus drive enable.

Behaviour:
- Reset (async, reset_n=0): state IDLE, isr=0, int_out=0, highest_priority=0, current_pulse=0, irr_clr=0, data_out=0, data_oe=0, lowest_prio=7 (IR0 highest).
- Priority order: circular starting at lowest_prio+1 mod 8. pend = irr & ~imr.
  - Winner = first pend bit in that order.
  - ISR top = first isr bit in that order.
- int_out is registered.
  - Set in IDLE when a pend winner exists ranked strictly above the ISR top, or isr=0.
  - Cleared on the cycle the first inta_n falling edge is detected.
  - Not re-evaluated until IDLE is re-entered.
- Edge detect: inta_q holds inta_n delayed one clk. fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- State IDLE:
  - On fall: latch highest_priority = winner and go P1.
  - If a winner exists: set isr[winner] and pulse irr_clr for exactly 1 cycle.
  - If no pend bit (spurious): level = 7, isr unchanged, no irr_clr.
  - current_pulse=0.
- State P1: wait for rise -> GAP.
- State GAP: on fall -> P2, current_pulse=1, data_out={vec_base, highest_priority}, data_oe=1 (registered, asserted on the cycle after fall).
- State P2: on rise -> IDLE with data_oe=0 and current_pulse=0.
  - If aeoi and not spurious: clear isr[highest_priority] on the same edge.
  - data_out holds its value.
- Changes to irr/imr after the first fall do not alter highest_priority or the vector.
- EOI (any state, on eoi_strobe):
  - Specific: clear isr[eoi_level].
  - Non-specific: clear the ISR top; no effect if isr=0.
  - eoi_rotate: lowest_prio = cleared level; ignored if nothing was cleared.
- Simultaneous events:
  - EOI and ISR set in the same cycle: both apply, set wins on the same bit.
  - EOI and AEOI clear in the same cycle: both apply.
- reset_n asserted mid-sequence: immediate return to reset values; data_oe drops asynchronously.
- A fall seen in P1 or P2, or a rise seen in GAP, is impossible per the protocol; the state holds.

Decomposition:
- Shared package pic_pkg holds:
  - state encoding (IDLE, P1, GAP, P2);
  - SPURIOUS_LVL = 3'd7;
  - function rot_first(vec, lowest), returning a found flag and the level.
- One sub-module: pic_priority_resolver, a combinational circular priority encoder. Instantiated twice, once for pend and once for isr.

Test Plan:
1. Fixed priority: reset; irr=8'b00100100, imr=0, vec_base=5'b01000.
   - int_out=1.
   - Two INTA pulses -> highest_priority=2, single irr_clr pulse, isr=8'h04, data_out=8'h42, data_oe high only in P2.
2. Masking and nesting:
   - isr=8'h04, irr=8'h01, imr=8'h01 -> int_out=0.
   - Clear imr -> int_out=1 (IR0 ranks above IR2).
   - irr=8'h08 with isr=8'h04 -> int_out stays 0.
3. Spurious: irr=0, run an INTA pair -> data_out={vec_base,3'd7}, isr unchanged, irr_clr never asserted.
4. AEOI: aeoi=1, irr=8'h10 -> isr[4] set after pulse 1, cleared on the pulse-2 rise; final isr=0.
5. EOI and rotation:
   - isr=8'h0A, non-specific EOI -> isr=8'h08.
   - Specific EOI on level 3 with eoi_rotate -> isr=0, lowest_prio=3.
   - Then irr=8'h11 resolves to level 4.
6. Reset mid-operation: reset_n low during P2 -> data_oe=0, isr=0, int_out=0 immediately; FSM in IDLE after release.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style INTA sequencer.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam int LVL_W  = 3;

  // Level reported when an INTA cycle finds no pending request.
  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    GAP  = 2'd2,
    P2   = 2'd3
  } state_t;

  typedef struct packed {
    logic             found;
    logic [LVL_W-1:0] level;
  } rot_t;

  // Scans vec starting just above the lowest-priority level and wrapping,
  // returning the first set bit found.
  function automatic rot_t rot_first(input logic [NUM_IR-1:0] vec,
                                     input logic [LVL_W-1:0] lowest);
    rot_t             r;
    logic [LVL_W-1:0] idx;
    r.found = 1'b0;
    r.level = SPURIOUS_LVL;
    for (int i = 1; i <= NUM_IR; i++) begin
      idx = lowest + LVL_W'(i);
      if (!r.found && vec[idx]) begin
        r.found = 1'b1;
        r.level = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational circular priority encoder; also reports the winner's rank
// (0 = highest) so two resolvers can be compared directly.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec,
  input  logic [LVL_W-1:0]  lowest,
  output logic              found,
  output logic [LVL_W-1:0]  level,
  output logic [LVL_W-1:0]  rank
);

  rot_t res;

  // Find the first set bit in rotated order and derive its rank.
  always_comb begin
    res   = rot_first(vec, lowest);
    found = res.found;
    level = res.level;
    rank  = res.level - lowest - LVL_W'(1);
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// Interrupt-acknowledge sequencer: raises INT, walks the two INTA pulses,
// sets/clears the in-service register and presents the vector.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic              inta_n,
  input  logic [4:0]        vec_base,
  input  logic              aeoi,
  input  logic              eoi_strobe,
  input  logic              eoi_specific,
  input  logic [LVL_W-1:0]  eoi_level,
  input  logic              eoi_rotate,
  output logic              int_out,
  output logic [NUM_IR-1:0] isr,
  output logic [LVL_W-1:0]  highest_priority,
  output logic              current_pulse,
  output logic              irr_clr,
  output logic [7:0]        data_out,
  output logic              data_oe
);

  state_t            state;
  logic              inta_q;
  logic              fall;
  logic              rise;
  logic              spurious;
  logic [LVL_W-1:0]  lowest_prio;
  logic [NUM_IR-1:0] pend;

  logic              win_found;
  logic [LVL_W-1:0]  win_level;
  logic [LVL_W-1:0]  win_rank;
  logic              top_found;
  logic [LVL_W-1:0]  top_level;
  logic [LVL_W-1:0]  top_rank;

  logic [NUM_IR-1:0] set_mask;
  logic [NUM_IR-1:0] eoi_mask;
  logic [NUM_IR-1:0] aeoi_mask;
  logic [NUM_IR-1:0] isr_next;
  logic              eoi_hit;
  logic [LVL_W-1:0]  eoi_lvl;
  logic              int_req;

  assign pend = irr & ~imr;
  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;

  pic_priority_resolver u_pend_res (
    .vec    (pend),
    .lowest (lowest_prio),
    .found  (win_found),
    .level  (win_level),
    .rank   (win_rank)
  );

  pic_priority_resolver u_isr_res (
    .vec    (isr),
    .lowest (lowest_prio),
    .found  (top_found),
    .level  (top_level),
    .rank   (top_rank)
  );

  // Build the ISR set/clear masks; a set on the same bit overrides any clear.
  always_comb begin
    set_mask  = '0;
    eoi_mask  = '0;
    aeoi_mask = '0;
    eoi_hit   = 1'b0;
    eoi_lvl   = eoi_level;
    if (state == IDLE && fall && win_found)
      set_mask = NUM_IR'(1) << win_level;
    if (eoi_strobe) begin
      if (eoi_specific) begin
        eoi_lvl = eoi_level;
        eoi_hit = isr[eoi_level];
      end else begin
        eoi_lvl = top_level;
        eoi_hit = top_found;
      end
    end
    if (eoi_hit)
      eoi_mask = NUM_IR'(1) << eoi_lvl;
    if (state == P2 && rise && aeoi && !spurious)
      aeoi_mask = NUM_IR'(1) << highest_priority;
    isr_next = (isr & ~eoi_mask & ~aeoi_mask) | set_mask;
    int_req  = win_found && (!top_found || (win_rank < top_rank));
  end

  // Acknowledge sequence FSM with all outputs registered; inta_q resets high
  // so the idle-high INTA line never looks like an edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      inta_q           <= 1'b1;
      isr              <= '0;
      int_out          <= 1'b0;
      highest_priority <= '0;
      current_pulse    <= 1'b0;
      irr_clr          <= 1'b0;
      data_out         <= '0;
      data_oe          <= 1'b0;
      spurious         <= 1'b0;
      lowest_prio      <= 3'd7;
    end else begin
      inta_q  <= inta_n;
      irr_clr <= 1'b0;
      isr     <= isr_next;
      if (eoi_strobe && eoi_rotate && eoi_hit)
        lowest_prio <= eoi_lvl;
      case (state)
        IDLE: begin
          if (fall) begin
            int_out          <= 1'b0;
            highest_priority <= win_found ? win_level : SPURIOUS_LVL;
            spurious         <= !win_found;
            irr_clr          <= win_found;
            current_pulse    <= 1'b0;
            state            <= P1;
          end else begin
            int_out <= int_req;
          end
        end
        P1: begin
          if (rise)
            state <= GAP;
        end
        GAP: begin
          if (fall) begin
            state         <= P2;
            current_pulse <= 1'b1;
            data_out      <= {vec_base, highest_priority};
            data_oe       <= 1'b1;
          end
        end
        P2: begin
          if (rise) begin
            state         <= IDLE;
            data_oe       <= 1'b0;
            current_pulse <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Scoreboard bench for pic_inta_sequencer with a behavioural priority model.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] irr, imr;
  logic       inta_n;
  logic [4:0] vec_base;
  logic       aeoi, eoi_strobe, eoi_specific, eoi_rotate;
  logic [2:0] eoi_level;
  logic       int_out, current_pulse, irr_clr, data_oe;
  logic [7:0] isr, data_out;
  logic [2:0] highest_priority;

  int total = 0;
  int bad = 0;
  int clr_count = 0;
  logic oe_prev = 1'b0;

  logic [7:0] m_isr;
  int         m_lowest;
  logic [7:0] exp_q[$];

  pic_inta_sequencer dut (
    .clk(clk), .reset_n(reset_n), .irr(irr), .imr(imr), .inta_n(inta_n),
    .vec_base(vec_base), .aeoi(aeoi), .eoi_strobe(eoi_strobe),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level), .eoi_rotate(eoi_rotate),
    .int_out(int_out), .isr(isr), .highest_priority(highest_priority),
    .current_pulse(current_pulse), .irr_clr(irr_clr), .data_out(data_out),
    .data_oe(data_oe)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // First set level scanning upward from just above the lowest-priority level; -1 if none.
  function automatic int first_in_order(input logic [7:0] v, input int lowest);
    for (int k = 1; k <= 8; k++) begin
      if (v[(lowest + k) % 8]) return (lowest + k) % 8;
    end
    return -1;
  endfunction

  function automatic int rank_of(input int lvl, input int lowest);
    return (lvl - lowest - 1 + 16) % 8;
  endfunction

  function automatic logic model_int();
    int w, t;
    w = first_in_order(irr & ~imr, m_lowest);
    t = first_in_order(m_isr, m_lowest);
    return (w >= 0) && ((t < 0) || (rank_of(w, m_lowest) < rank_of(t, m_lowest)));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: counts irr_clr pulses and checks each vector against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      oe_prev = 1'b0;
    end else begin
      if (irr_clr) clr_count++;
      if (data_oe && !oe_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_vector: got %0h expected none", data_out);
        end else begin
          checkOutput("vector", 32'(data_out), 32'(exp_q.pop_front()));
          checkOutput("pulse2_flag", 32'(current_pulse), 32'(1));
        end
      end
      oe_prev = data_oe;
    end
  end

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m,
                               input logic [4:0] vb, input logic a);
    irr = r; imr = m; vec_base = vb; aeoi = a;
    wait_cycles(2);
    checkOutput("int_out", 32'(int_out), 32'(model_int()));
  endtask

  task automatic doEoi(input logic spec, input logic [2:0] lvl, input logic rot);
    int  cl;
    logic hit;
    if (spec) begin
      cl = int'(lvl);
      hit = m_isr[lvl];
    end else begin
      cl = first_in_order(m_isr, m_lowest);
      hit = (cl >= 0);
    end
    if (hit) m_isr[cl] = 1'b0;
    if (hit && rot) m_lowest = cl;
    eoi_strobe = 1'b1; eoi_specific = spec; eoi_level = lvl; eoi_rotate = rot;
    wait_cycles(1);
    eoi_strobe = 1'b0;
    wait_cycles(1);
    checkOutput("isr_eoi", 32'(isr), 32'(m_isr));
  endtask

  task automatic intaPair(input logic mid_change);
    int w, lvl, c0;
    w = first_in_order(irr & ~imr, m_lowest);
    lvl = (w >= 0) ? w : 7;
    if (w >= 0) m_isr[w] = 1'b1;
    exp_q.push_back({vec_base, 3'(lvl)});
    c0 = clr_count;
    inta_n = 1'b0;
    wait_cycles(1);
    checkOutput("hp_latch", 32'(highest_priority), 32'(lvl));
    checkOutput("isr_p1", 32'(isr), 32'(m_isr));
    checkOutput("oe_p1", 32'(data_oe), 32'(0));
    checkOutput("int_cleared", 32'(int_out), 32'(0));
    if (w >= 0) irr[w] = 1'b0;
    if (mid_change) begin
      irr = 8'($urandom);
      imr = 8'($urandom);
    end
    wait_cycles(1);
    inta_n = 1'b1;
    wait_cycles(2);
    inta_n = 1'b0;
    wait_cycles(2);
    checkOutput("oe_p2", 32'(data_oe), 32'(1));
    inta_n = 1'b1;
    wait_cycles(1);
    if (aeoi && w >= 0) m_isr[w] = 1'b0;
    checkOutput("oe_off", 32'(data_oe), 32'(0));
    checkOutput("pulse_off", 32'(current_pulse), 32'(0));
    checkOutput("isr_end", 32'(isr), 32'(m_isr));
    checkOutput("irr_clr_count", 32'(clr_count - c0), 32'((w >= 0) ? 1 : 0));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Directed plan followed by randomized traffic.
  initial begin
    reset_n = 1'b0; irr = '0; imr = '0; inta_n = 1'b1; vec_base = '0; aeoi = 1'b0;
    eoi_strobe = 1'b0; eoi_specific = 1'b0; eoi_level = '0; eoi_rotate = 1'b0;
    m_isr = '0; m_lowest = 7;
    wait_cycles(2);
    checkOutput("rst_isr", 32'(isr), 32'(0));
    checkOutput("rst_int", 32'(int_out), 32'(0));
    checkOutput("rst_hp", 32'(highest_priority), 32'(0));
    checkOutput("rst_oe", 32'(data_oe), 32'(0));
    checkOutput("rst_data", 32'(data_out), 32'(0));
    checkOutput("rst_clr", 32'(irr_clr), 32'(0));
    reset_n = 1'b1;
    wait_cycles(1);

    $display("[TB] fixed priority");
    applyStimulus(8'b00100100, 8'h00, 5'b01000, 1'b0);
    checkOutput("t1_int", 32'(int_out), 32'(1));
    intaPair(1'b0);
    checkOutput("t1_isr", 32'(isr), 32'(8'h04));

    $display("[TB] masking and nesting");
    applyStimulus(8'h01, 8'h01, 5'b01000, 1'b0);
    applyStimulus(8'h01, 8'h00, 5'b01000, 1'b0);
    checkOutput("t2_nest", 32'(int_out), 32'(1));
    applyStimulus(8'h08, 8'h00, 5'b01000, 1'b0);
    checkOutput("t2_lower", 32'(int_out), 32'(0));

    $display("[TB] spurious");
    applyStimulus(8'h00, 8'h00, 5'b10101, 1'b0);
    intaPair(1'b0);

    $display("[TB] aeoi");
    doEoi(1'b0, 3'd0, 1'b0);
    applyStimulus(8'h10, 8'h00, 5'b00011, 1'b1);
    intaPair(1'b0);
    checkOutput("t4_isr", 32'(isr), 32'(0));

    $display("[TB] eoi and rotation");
    applyStimulus(8'h02, 8'h00, 5'b00110, 1'b0);
    intaPair(1'b0);
    applyStimulus(8'h08, 8'h00, 5'b00110, 1'b0);
    intaPair(1'b0);
    checkOutput("t5_isr0a", 32'(isr), 32'(8'h0A));
    doEoi(1'b0, 3'd0, 1'b0);
    checkOutput("t5_nseoi", 32'(isr), 32'(8'h08));
    doEoi(1'b1, 3'd3, 1'b1);
    applyStimulus(8'h11, 8'h00, 5'b00110, 1'b0);
    intaPair(1'b0);
    checkOutput("t5_rot_hp", 32'(highest_priority), 32'(4));

    $display("[TB] reset mid-sequence");
    doEoi(1'b0, 3'd0, 1'b0);
    applyStimulus(8'h20, 8'h00, 5'b11100, 1'b0);
    exp_q.push_back({vec_base, 3'(first_in_order(irr & ~imr, m_lowest))});
    inta_n = 1'b0; wait_cycles(2);
    inta_n = 1'b1; wait_cycles(2);
    inta_n = 1'b0; wait_cycles(2);
    checkOutput("t6_oe_before", 32'(data_oe), 32'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("t6_oe", 32'(data_oe), 32'(0));
    checkOutput("t6_isr", 32'(isr), 32'(0));
    checkOutput("t6_int", 32'(int_out), 32'(0));
    m_isr = '0; m_lowest = 7;
    inta_n = 1'b1;
    wait_cycles(2);
    reset_n = 1'b1;
    applyStimulus(8'h20, 8'h00, 5'b11100, 1'b0);
    intaPair(1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0)
        doEoi(1'($urandom), 3'($urandom), 1'($urandom));
      intaPair(1'($urandom));
    end

    wait_cycles(2);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
